uart_tx_ctrl: RTL
=================

// Module: uart_tx_ctrl
// PURPOSE
//   Frame sequencer for the UART transmitter. Accepts a byte request, times each
//   bit period from a programmable prescaler, and drives the output mux select and
//   the serializer load/shift strobes: start -> data -> optional parity -> stop.
//   Sits between the host-side request interface and the serializer/parity/mux datapath.
// PARAMETERS
//   DATA_WIDTH  8   data bits per frame (1..16)
//   PRESC_W     16  width of PRESCALE port (clock cycles per bit)
// PORTS
//   CLK         in   1         system clock, rising edge
//   RST         in   1         asynchronous, active-high reset
//   DATA_VALID  in   1         request to send; the serializer holds P_DATA while it is high
//   PAR_EN      in   1         parity bit inserted when 1; sampled at accept
//   PRESCALE    in   PRESC_W   cycles per bit; sampled at accept; 0 treated as 1
//   ser_load    out  1         1-cycle pulse: serializer/parity calc capture P_DATA
//   ser_shift   out  1         1-cycle pulse: serializer advances to next data bit
//   mux_sel     out  2         00 start, 01 serial, 10 parity, 11 stop/idle
//   busy        out  1         high from accept until frame end
// BEHAVIOUR
//   - All outputs registered. Reset (async, any time, incl. mid-frame): state IDLE,
//     mux_sel=11 (line high), busy=0, ser_load=0, ser_shift=0, counters=0.
//   - States: IDLE, START, DATA, PARITY, STOP.
//   - Accept: IDLE and DATA_VALID=1 at edge -> next cycle state START, busy=1,
//     mux_sel=00, ser_load=1 (one cycle only). PAR_EN and PRESCALE latched here.
//   - Baud counter: counts 0..P-1 per bit (P = latched PRESCALE, min 1); bit ends
//     when count==P-1; counter clears at every state change.
//   - START: 1 bit period -> DATA, mux_sel=01.
//   - DATA: bit counter 0..DATA_WIDTH-1; ser_shift=1 on the last cycle of every data
//     bit (DATA_WIDTH pulses per frame). After bit DATA_WIDTH-1 -> PARITY (mux_sel=10)
//     if latched PAR_EN, else STOP (mux_sel=11).
//   - PARITY: 1 bit period -> STOP.
//   - STOP: 1 bit period. At the last cycle: if DATA_VALID=1 -> START directly
//     (back-to-back, ser_load pulse, busy stays 1); else -> IDLE, busy=0.
//   - DATA_VALID is ignored in all states except IDLE and the last STOP cycle.
//   - PRESCALE/PAR_EN changes mid-frame have no effect until the next accept.
//   - Frame length = (2 + DATA_WIDTH + PAR_EN) * P cycles, first START cycle to
//     last STOP cycle inclusive.
//   - Bit counter width = $clog2(DATA_WIDTH+1); baud counter width = PRESC_W;
//     no wrap within a legal frame.
//   - Outputs are never X after reset; unused state encodings recover to IDLE.
// STRUCTURE
//   - Shared include uart_tx_defines.vh: mux_sel encodings (MUX_START/SERIAL/PARITY/STOP)
//     and FSM state encodings; the mux, serializer and this block all use it.
//   - Sub-module uart_tx_baud_cnt: prescale counter with clear and bit_end output.
//   - FSM, bit counter, and output registers stay in this module.
// TESTING
//   - Reset: RST=1 mid-DATA, P=4 -> same cycle mux_sel=11, busy=0; no pulses after release.
//   - DATA_WIDTH=8, PAR_EN=0, P=1, one DATA_VALID pulse -> mux_sel 00, 01x8, 11;
//     busy high 10 cycles; 1 ser_load, 8 ser_shift.
//   - PAR_EN=1, P=4 -> frame 44 cycles; mux_sel=10 for exactly 4 cycles after the
//     32 DATA cycles.
//   - DATA_VALID held high, P=2, PAR_EN=0 -> STOP goes straight to START; busy never
//     drops; frame period 20 cycles.
//   - PRESCALE=0 -> each bit lasts 1 cycle; PRESCALE changed 3->7 mid-frame -> current
//     frame keeps 3, next frame uses 7.
//   - DATA_VALID pulse during DATA -> ignored; exactly one frame is sent, then IDLE.

Source files
------------

// File: rtl/uart_tx_ctrl_pkg.sv
// Shared encodings for the UART transmit path: FSM states and output mux selects.
package uart_tx_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic [1:0] MUX_START  = 2'b00;
  localparam logic [1:0] MUX_SERIAL = 2'b01;
  localparam logic [1:0] MUX_PARITY = 2'b10;
  localparam logic [1:0] MUX_STOP   = 2'b11;

  // Line source for a given state; idle and stop both keep the line high.
  function automatic logic [1:0] mux_for(input state_t s);
    case (s)
      S_START:  return MUX_START;
      S_DATA:   return MUX_SERIAL;
      S_PARITY: return MUX_PARITY;
      default:  return MUX_STOP;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_baud_cnt.sv
// Bit-period counter: counts 0..last, flags the final cycle of a bit and
// predicts whether the following cycle will be a final cycle.
module uart_tx_baud_cnt #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [PRESC_W-1:0] last,
  output logic               bit_end,
  output logic               bit_end_next
);

  logic [PRESC_W-1:0] cnt;
  logic [PRESC_W-1:0] cnt_next;

  // Next count: restart at a bit boundary or when the controller clears it.
  always_comb begin
    cnt_next     = (clear || bit_end) ? '0 : cnt + 1'b1;
    bit_end_next = (cnt_next == last);
  end

  assign bit_end = (cnt == last);

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_next;
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start -> data -> optional parity -> stop,
// with registered mux select, load/shift strobes and busy.
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               DATA_VALID,
  input  logic               PAR_EN,
  input  logic [PRESC_W-1:0] PRESCALE,
  output logic               ser_load,
  output logic               ser_shift,
  output logic [1:0]         mux_sel,
  output logic               busy
);

  localparam int               BIT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  state_t             state;
  state_t             state_next;
  logic               accept;
  logic               cnt_clear;
  logic               bit_end;
  logic               bit_end_next;
  logic [PRESC_W-1:0] p_last;
  logic               par_lat;
  logic [BIT_W-1:0]   bit_cnt;

  // Baud counter is held at zero while idle and restarted on every state change.
  assign cnt_clear = (state_next != state) || (state == S_IDLE);

  uart_tx_baud_cnt #(
    .PRESC_W (PRESC_W)
  ) u_baud (
    .clk          (CLK),
    .rst          (RST),
    .clear        (cnt_clear),
    .last         (p_last),
    .bit_end      (bit_end),
    .bit_end_next (bit_end_next)
  );

  // Next-state logic; accept marks a new frame (from idle or back-to-back from stop).
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (DATA_VALID) begin
          state_next = S_START;
          accept     = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) state_next = S_DATA;
      end
      S_DATA: begin
        if (bit_end && (bit_cnt == LAST_BIT))
          state_next = par_lat ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (bit_end) state_next = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (DATA_VALID) begin
            state_next = S_START;
            accept     = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_next;
  end

  // Frame configuration is captured only at accept; mid-frame changes wait for the next frame.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      p_last  <= '0;
      par_lat <= 1'b0;
    end else if (accept) begin
      p_last  <= (PRESCALE == '0) ? '0 : PRESCALE - 1'b1;
      par_lat <= PAR_EN;
    end
  end

  // Data bit index, advanced at the end of each data bit and cleared outside DATA.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                          bit_cnt <= '0;
    else if (state != S_DATA || state_next != S_DATA) bit_cnt <= '0;
    else if (bit_end)                                 bit_cnt <= bit_cnt + 1'b1;
  end

  // Registered outputs, computed from the upcoming state so they align with it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mux_sel   <= MUX_STOP;
      busy      <= 1'b0;
      ser_load  <= 1'b0;
      ser_shift <= 1'b0;
    end else begin
      mux_sel   <= mux_for(state_next);
      busy      <= (state_next != S_IDLE);
      ser_load  <= accept;
      ser_shift <= (state_next == S_DATA) && bit_end_next;
    end
  end

endmodule
